// File: rtl/miner_pkg.sv
// Shared definitions for the miner array controller: FSM states, default widths
// and a population-count helper used for result accounting.
package miner_pkg;

  localparam int NONCE_W_DEFAULT = 32;
  localparam int HASH_W_DEFAULT  = 256;
  localparam int MAX_CORES       = 16;

  typedef enum logic [2:0] {
    IDLE,
    SEARCH,
    DRAIN,
    FOUND,
    EXHAUSTED
  } minerState_t;

  function automatic logic [4:0] popCount(input logic [MAX_CORES-1:0] vec);
    logic [4:0] total;
    total = '0;
    for (int i = 0; i < MAX_CORES; i++) begin
      total = total + {4'b0, vec[i]};
    end
    return total;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Lowest-index-first request picker; returns whether any request is set and its index.
module prio_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  // Scan high to low so the last match written is the lowest index.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        any = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/miner_array_ctrl.sv
// Dispatches a nonce range across an array of hash cores, collects results and
// reports the first (lowest-index) winning nonce or range exhaustion.
module miner_array_ctrl
  import miner_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int NONCE_W   = NONCE_W_DEFAULT,
  parameter int HEADER_W  = 640,
  parameter int HASH_W    = HASH_W_DEFAULT
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic [HEADER_W-1:0]           header_in,
  input  logic [NONCE_W-1:0]            nonce_first,
  input  logic [NONCE_W-1:0]            nonce_last,
  output logic [HEADER_W-1:0]           core_header,
  output logic [NUM_CORES-1:0]          core_start,
  output logic [NUM_CORES*NONCE_W-1:0]  core_nonce,
  output logic                          core_flush,
  input  logic [NUM_CORES-1:0]          core_done,
  input  logic [NUM_CORES-1:0]          core_hit,
  input  logic [NUM_CORES*HASH_W-1:0]   core_hash,
  output logic                          busy,
  output logic                          found,
  output logic [NONCE_W-1:0]            found_nonce,
  output logic [HASH_W-1:0]             found_hash,
  output logic                          exhausted,
  output logic [31:0]                   hash_count
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [HEADER_W-1:0] HEADER_MASK = {{(HEADER_W-NONCE_W){1'b1}}, {NONCE_W{1'b0}}};

  minerState_t          state;
  logic [NONCE_W:0]     nextNonce;
  logic [NONCE_W-1:0]   lastNonce;
  logic [NUM_CORES-1:0] coreBusy;
  logic [NONCE_W-1:0]   issuedNonce [NUM_CORES];
  logic [HASH_W-1:0]    coreHashArr [NUM_CORES];

  logic [NUM_CORES-1:0] doneQual;
  logic [NUM_CORES-1:0] hitQual;
  logic [NUM_CORES-1:0] stillBusy;
  logic [MAX_CORES-1:0] doneWide;
  logic [32:0]          countSum;
  logic                 issueAny;
  logic                 hitAny;
  logic [IDX_W-1:0]     issueIdx;
  logic [IDX_W-1:0]     hitIdx;
  logic                 rangeDone;

  generate
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_hashSlice
      assign coreHashArr[gi] = core_hash[gi*HASH_W +: HASH_W];
    end
  endgenerate

  // Results from cores we never launched (or already flushed) are dropped here.
  assign doneQual  = core_done & coreBusy;
  assign hitQual   = doneQual & core_hit;
  assign stillBusy = coreBusy & ~doneQual;
  assign doneWide  = MAX_CORES'(doneQual);
  assign countSum  = {1'b0, hash_count} + 33'(popCount(doneWide));
  assign rangeDone = nextNonce > {1'b0, lastNonce};
  assign busy      = (state == SEARCH) || (state == DRAIN);

  prio_pick #(.N(NUM_CORES), .IDX_W(IDX_W)) issuePick (
    .req (~coreBusy),
    .any (issueAny),
    .idx (issueIdx)
  );

  prio_pick #(.N(NUM_CORES), .IDX_W(IDX_W)) hitPick (
    .req (hitQual),
    .any (hitAny),
    .idx (hitIdx)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      nextNonce   <= '0;
      lastNonce   <= '0;
      coreBusy    <= '0;
      core_header <= '0;
      core_start  <= '0;
      core_nonce  <= '0;
      core_flush  <= 1'b0;
      found       <= 1'b0;
      found_nonce <= '0;
      found_hash  <= '0;
      exhausted   <= 1'b0;
      hash_count  <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        issuedNonce[i] <= '0;
      end
    end else begin
      core_start <= '0;
      core_flush <= 1'b0;
      case (state)
        SEARCH, DRAIN: begin
          hash_count <= countSum[32] ? '1 : countSum[31:0];
          if (abort) begin
            core_flush <= 1'b1;
            coreBusy   <= '0;
            state      <= IDLE;
          end else if (hitAny) begin
            found       <= 1'b1;
            found_nonce <= issuedNonce[hitIdx];
            found_hash  <= coreHashArr[hitIdx];
            core_flush  <= 1'b1;
            coreBusy    <= '0;
            state       <= FOUND;
          end else if (state == DRAIN || rangeDone) begin
            coreBusy <= stillBusy;
            if (stillBusy == '0) begin
              exhausted <= 1'b1;
              state     <= EXHAUSTED;
            end else begin
              state <= DRAIN;
            end
          end else if (issueAny) begin
            core_start                           <= NUM_CORES'(1) << issueIdx;
            core_nonce[issueIdx*NONCE_W +: NONCE_W] <= nextNonce[NONCE_W-1:0];
            issuedNonce[issueIdx]                <= nextNonce[NONCE_W-1:0];
            coreBusy                             <= stillBusy | (NUM_CORES'(1) << issueIdx);
            nextNonce                            <= nextNonce + 1'b1;
          end else begin
            coreBusy <= stillBusy;
          end
        end
        default: begin
          // IDLE, FOUND and EXHAUSTED all accept a new job; abort only clears status.
          if (abort) begin
            found     <= 1'b0;
            exhausted <= 1'b0;
            state     <= IDLE;
          end else if (start) begin
            core_header <= header_in & HEADER_MASK;
            nextNonce   <= {1'b0, nonce_first};
            lastNonce   <= nonce_last;
            coreBusy    <= '0;
            found       <= 1'b0;
            found_nonce <= '0;
            found_hash  <= '0;
            exhausted   <= 1'b0;
            hash_count  <= '0;
            state       <= SEARCH;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_miner_array_ctrl.sv
// Directed bench for miner_array_ctrl: four behavioural fixed-latency cores,
// an issue/flush monitor and hand-computed expectations per scenario.
module tb_miner_array_ctrl;

  localparam int NC  = 4;
  localparam int NW  = 32;
  localparam int HW  = 640;
  localparam int SW  = 256;
  localparam int LAT = 10;

  logic           clock = 1'b0;
  logic           reset;
  logic           start;
  logic           abort;
  logic [HW-1:0]  header_in;
  logic [NW-1:0]  nonce_first;
  logic [NW-1:0]  nonce_last;
  logic [HW-1:0]  core_header;
  logic [NC-1:0]  core_start;
  logic [NC*NW-1:0] core_nonce;
  logic           core_flush;
  logic [NC-1:0]  core_done;
  logic [NC-1:0]  core_hit;
  logic [NC*SW-1:0] core_hash;
  logic           busy;
  logic           found;
  logic [NW-1:0]  found_nonce;
  logic [SW-1:0]  found_hash;
  logic           exhausted;
  logic [31:0]    hash_count;

  miner_array_ctrl #(.NUM_CORES(NC), .NONCE_W(NW), .HEADER_W(HW), .HASH_W(SW)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .header_in   (header_in),
    .nonce_first (nonce_first),
    .nonce_last  (nonce_last),
    .core_header (core_header),
    .core_start  (core_start),
    .core_nonce  (core_nonce),
    .core_flush  (core_flush),
    .core_done   (core_done),
    .core_hit    (core_hit),
    .core_hash   (core_hash),
    .busy        (busy),
    .found       (found),
    .found_nonce (found_nonce),
    .found_hash  (found_hash),
    .exhausted   (exhausted),
    .hash_count  (hash_count)
  );

  always #5 clock = ~clock;

  int nCompared   = 0;
  int nMismatched = 0;
  int issueTotal  = 0;
  int flushCount  = 0;
  int issueBase;
  int flushBase;
  logic [7:0]  jobId = 8'd0;
  logic [39:0] monKey;
  int issueCnt  [logic [39:0]];
  int issueCore [logic [39:0]];
  int tmr [NC];
  logic [31:0] mdlNonce [NC];
  logic [31:0] hitA;
  logic [31:0] hitB;
  logic [31:0] slowNonce;
  bit hitAEn;
  bit hitBEn;
  bit slowEn;

  function automatic logic [SW-1:0] hashOf(input logic [31:0] n);
    return {8{n ^ 32'h5A5A1234}};
  endfunction

  function automatic int issuedTimes(input logic [31:0] n);
    logic [39:0] k;
    k = {jobId, n};
    return issueCnt.exists(k) ? issueCnt[k] : 0;
  endfunction

  function automatic int coreOf(input logic [31:0] n);
    logic [39:0] k;
    k = {jobId, n};
    return issueCore.exists(k) ? issueCore[k] : -1;
  endfunction

  task automatic checkEq(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Monitor plus core model: launches take LAT cycles (LAT+2 for slowNonce), flush kills work.
  always @(negedge clock) begin
    core_done = '0;
    core_hit  = '0;
    if (!reset) begin
      for (int i = 0; i < NC; i++) begin
        if (core_start[i]) begin
          monKey = {jobId, core_nonce[i*NW +: NW]};
          issueTotal++;
          issueCnt[monKey]  = issueCnt.exists(monKey) ? issueCnt[monKey] + 1 : 1;
          issueCore[monKey] = i;
        end
      end
      if (core_flush) flushCount++;
    end
    for (int i = 0; i < NC; i++) begin
      if (core_flush) begin
        tmr[i] = 0;
      end else if (tmr[i] > 0) begin
        tmr[i] = tmr[i] - 1;
        if (tmr[i] == 0) begin
          core_done[i] = 1'b1;
          core_hit[i]  = (hitAEn && mdlNonce[i] == hitA) || (hitBEn && mdlNonce[i] == hitB);
        end
      end
      if (core_start[i]) begin
        mdlNonce[i] = core_nonce[i*NW +: NW];
        tmr[i] = (slowEn && mdlNonce[i] == slowNonce) ? LAT + 2 : LAT;
        core_hash[i*SW +: SW] = hashOf(mdlNonce[i]);
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic startJob(input logic [31:0] f, input logic [31:0] l);
    jobId++;
    issueBase   = issueTotal;
    flushBase   = flushCount;
    nonce_first = f;
    nonce_last  = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitEnd(input string tag, input int maxCycles);
    int k;
    k = 0;
    while (!(found || exhausted) && k < maxCycles) begin
      tick();
      k++;
    end
    checkEq(tag, SW'(found || exhausted), SW'(1));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    header_in   = {20{32'hC0FFEE11}};
    nonce_first = '0;
    nonce_last  = '0;
    hitAEn = 0; hitBEn = 0; slowEn = 0;
    hitA = '0; hitB = '0; slowNonce = '0;
    repeat (3) tick();
    checkEq("rst_busy", SW'(busy), SW'(0));
    checkEq("rst_found", SW'(found), SW'(0));
    checkEq("rst_exhausted", SW'(exhausted), SW'(0));
    checkEq("rst_hash_count", SW'(hash_count), SW'(0));
    checkEq("rst_core_start", SW'(core_start), SW'(0));
    checkEq("rst_core_flush", SW'(core_flush), SW'(0));
    reset = 1'b0;
    tick();

    // Range 0..15 with a hit on nonce 9.
    hitAEn = 1; hitA = 32'd9;
    startJob(32'd0, 32'd15);
    waitEnd("t43_end", 300);
    tick(); tick();
    checkEq("t43_found", SW'(found), SW'(1));
    checkEq("t43_found_nonce", SW'(found_nonce), SW'(9));
    checkEq("t43_found_hash", found_hash, hashOf(32'd9));
    checkEq("t43_flush_once", SW'(flushCount - flushBase), SW'(1));
    checkEq("t43_count_le16", SW'(hash_count <= 32'd16), SW'(1));
    checkEq("t43_busy", SW'(busy), SW'(0));
    checkEq("t43_header_hi", core_header[HW-1 -: SW], header_in[HW-1 -: SW]);
    hitAEn = 0;
    repeat (5) tick();

    // Range 0..7, no hits; a start while busy must be ignored.
    startJob(32'd0, 32'd7);
    repeat (3) tick();
    nonce_first = 32'd50; nonce_last = 32'd60;
    start = 1'b1; tick(); start = 1'b0;
    waitEnd("t44_end", 300);
    checkEq("t44_exhausted", SW'(exhausted), SW'(1));
    checkEq("t44_found", SW'(found), SW'(0));
    checkEq("t44_hash_count", SW'(hash_count), SW'(8));
    checkEq("t44_issues", SW'(issueTotal - issueBase), SW'(8));
    for (int n = 0; n < 8; n++) begin
      checkEq($sformatf("t44_once_%0d", n), SW'(issuedTimes(32'(n))), SW'(1));
    end
    checkEq("t44_no_restart", SW'(issuedTimes(32'd50)), SW'(0));
    checkEq("t44_busy", SW'(busy), SW'(0));
    checkEq("t44_no_flush", SW'(flushCount - flushBase), SW'(0));
    repeat (5) tick();

    // Cores 1 and 3 complete hits on nonces 5 and 7 in the same cycle.
    hitAEn = 1; hitA = 32'd5; hitBEn = 1; hitB = 32'd7;
    slowEn = 1; slowNonce = 32'd5;
    startJob(32'd4, 32'd7);
    waitEnd("t45_end", 300);
    tick();
    checkEq("t45_core_of_5", SW'(coreOf(32'd5)), SW'(1));
    checkEq("t45_core_of_7", SW'(coreOf(32'd7)), SW'(3));
    checkEq("t45_found_nonce", SW'(found_nonce), SW'(5));
    checkEq("t45_found_hash", found_hash, hashOf(32'd5));
    checkEq("t45_hash_count", SW'(hash_count), SW'(4));
    checkEq("t45_flush_once", SW'(flushCount - flushBase), SW'(1));
    hitAEn = 0; hitBEn = 0; slowEn = 0;
    repeat (5) tick();

    // Single nonce at the top of the range must not wrap.
    startJob(32'hFFFFFFFF, 32'hFFFFFFFF);
    waitEnd("t46_end", 300);
    checkEq("t46_exhausted", SW'(exhausted), SW'(1));
    checkEq("t46_issues", SW'(issueTotal - issueBase), SW'(1));
    checkEq("t46_top_once", SW'(issuedTimes(32'hFFFFFFFF)), SW'(1));
    checkEq("t46_no_wrap", SW'(issuedTimes(32'd0)), SW'(0));
    checkEq("t46_hash_count", SW'(hash_count), SW'(1));
    repeat (5) tick();

    // Abort after three issues, then a fresh 100..101 job.
    startJob(32'd0, 32'd15);
    for (int k = 0; k < 50 && (issueTotal - issueBase) < 3; k++) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    tick(); tick();
    checkEq("t47_issues", SW'(issueTotal - issueBase), SW'(3));
    checkEq("t47_flush", SW'(flushCount - flushBase), SW'(1));
    checkEq("t47_busy", SW'(busy), SW'(0));
    checkEq("t47_found", SW'(found), SW'(0));
    checkEq("t47_exhausted", SW'(exhausted), SW'(0));
    repeat (15) tick();
    startJob(32'd100, 32'd101);
    waitEnd("t47b_end", 300);
    checkEq("t47b_issues", SW'(issueTotal - issueBase), SW'(2));
    checkEq("t47b_100", SW'(issuedTimes(32'd100)), SW'(1));
    checkEq("t47b_101", SW'(issuedTimes(32'd101)), SW'(1));
    checkEq("t47b_exhausted", SW'(exhausted), SW'(1));
    checkEq("t47b_hash_count", SW'(hash_count), SW'(2));
    repeat (5) tick();

    // Reset while draining; late core_done pulses must be ignored.
    startJob(32'd0, 32'd3);
    for (int k = 0; k < 50 && (issueTotal - issueBase) < 4; k++) tick();
    tick(); tick();
    checkEq("t48_busy_drain", SW'(busy), SW'(1));
    reset = 1'b1; tick();
    checkEq("t48_rst_busy", SW'(busy), SW'(0));
    checkEq("t48_rst_found", SW'(found), SW'(0));
    checkEq("t48_rst_exhausted", SW'(exhausted), SW'(0));
    checkEq("t48_rst_core_start", SW'(core_start), SW'(0));
    checkEq("t48_rst_core_flush", SW'(core_flush), SW'(0));
    checkEq("t48_rst_found_nonce", SW'(found_nonce), SW'(0));
    checkEq("t48_rst_hash_count", SW'(hash_count), SW'(0));
    reset = 1'b0;
    repeat (20) tick();
    checkEq("t48_spurious_count", SW'(hash_count), SW'(0));
    checkEq("t48_after_busy", SW'(busy), SW'(0));
    checkEq("t48_after_exhausted", SW'(exhausted), SW'(0));
    checkEq("t48_no_flush", SW'(flushCount - flushBase), SW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/miner_array_ctrl.md
MINER_ARRAY_CTRL -- requirements
Module: miner_array_ctrl

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of hash cores driven (1..16).
REQ-002 SHALL have parameter NONCE_W, default 32, nonce width.
REQ-003 SHALL have parameter HEADER_W, default 640, block header width.
REQ-004 SHALL have parameter HASH_W, default 256, hash width.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clock  in  1  sole clock, all logic on posedge; reset  in  1  synchronous active-high reset.
REQ-006 SHALL have start  in  1  pulse; latch job and begin search.
REQ-007 SHALL have abort  in  1  pulse; cancel current job.
REQ-008 SHALL have header_in  in  HEADER_W  job header; low NONCE_W bits ignored.
REQ-009 SHALL have nonce_first, nonce_last  in  NONCE_W each  inclusive search range.
REQ-010 SHALL have core_header  out  HEADER_W  latched header, shared by all cores.
REQ-011 SHALL have core_start  out  NUM_CORES  one-cycle launch pulse per core.
REQ-012 SHALL have core_nonce  out  NUM_CORES*NONCE_W  nonce for each core, valid when its core_start is high.
REQ-013 SHALL have core_flush  out  1  one-cycle pulse; cores abandon work.
REQ-014 SHALL have core_done  in  NUM_CORES  one-cycle result pulse per core.
REQ-015 SHALL have core_hit  in  NUM_CORES  qualified by core_done; hash meets target.
REQ-016 SHALL have core_hash  in  NUM_CORES*HASH_W  qualified by core_done.
REQ-017 SHALL have busy  out  1  job in progress.
REQ-018 SHALL have found  out  1  sticky until next start/abort/reset.
REQ-019 SHALL have found_nonce  out  NONCE_W  winning nonce.
REQ-020 SHALL have found_hash  out  HASH_W  winning hash.
REQ-021 SHALL have exhausted  out  1  sticky; range finished with no hit.
REQ-022 SHALL have hash_count  out  32  non-hit and hit results received this job, saturating.

Function
REQ-023 SHALL implement FSM states IDLE, SEARCH, DRAIN, FOUND, EXHAUSTED.
REQ-024 IDLE: on start, latch header_in/range, set next_nonce = nonce_first, clear found/exhausted/hash_count, go SEARCH next cycle.
REQ-025 SEARCH: issue next_nonce to at most one idle core per cycle, lowest index first; mark core busy; increment next_nonce.
REQ-026 next_nonce counter SHALL be NONCE_W+1 bits; range done when next_nonce > nonce_last, so nonce_last = all-ones terminates without wrap.
REQ-027 nonce_first > nonce_last SHALL yield zero issues and EXHAUSTED one cycle after SEARCH entry.
REQ-028 core_done from a core SHALL mark it idle same cycle; that core is eligible for reissue the following cycle.
REQ-029 core_done on a core not marked busy SHALL be ignored (not counted).
REQ-030 Controller SHALL keep a per-core record of issued nonce to report found_nonce.
REQ-031 Any qualified hit SHALL: latch lowest-index hitting core's nonce/hash, assert found, pulse core_flush, go FOUND; simultaneous hits resolved by lowest index.
REQ-032 Range done in SEARCH with cores busy SHALL go DRAIN; DRAIN issues nothing, still accepts hits.
REQ-033 DRAIN with all cores idle and no hit SHALL go EXHAUSTED, assert exhausted.
REQ-034 FOUND/EXHAUSTED SHALL hold outputs; start begins new job as in IDLE.
REQ-035 abort in SEARCH/DRAIN SHALL pulse core_flush, clear all busy marks, go IDLE; found/exhausted stay 0.
REQ-036 start while busy SHALL be ignored; abort and start same cycle: abort wins.
REQ-037 busy SHALL be 1 exactly in SEARCH and DRAIN.
REQ-038 hash_count SHALL increment once per qualified core_done, by popcount when several cores complete in one cycle, saturating at all-ones.

Reset
REQ-039 Reset SHALL force IDLE; busy, found, exhausted, core_start, core_flush, found_nonce, found_hash, hash_count, busy marks all 0.
REQ-040 Reset mid-search SHALL NOT pulse core_flush; cores share reset.

Structure
REQ-041 State encoding and NONCE_W/HASH_W defaults SHALL live in shared package miner_pkg.
REQ-042 Lowest-index priority selection SHALL be sub-module prio_pick, reused for issue and hit selection.

Verification
REQ-043 NUM_CORES=4, fixed-latency 10-cycle core model, range 0..15, hit on nonce 9 -> found=1, found_nonce=9, flush pulse once, hash_count<=16.
REQ-044 Range 0..7, no hits -> exhausted=1 after last done, hash_count=8, each nonce issued exactly once.
REQ-045 Cores 1 and 3 hit same cycle (nonces 5, 7) -> found_nonce=5.
REQ-046 nonce_first=nonce_last=32'hFFFFFFFF, no hit -> exactly one issue, exhausted, no wrap to 0.
REQ-047 abort after 3 issues -> core_flush pulse, IDLE, busy=0; new start range 100..101 issues 100, 101 only.
REQ-048 reset asserted in DRAIN -> all outputs 0 next cycle, later spurious core_done ignored.
